extrinsic_interleaver: RTL and testbench

Block buffer between two SISO decoder instances of the turbo loop. It captures one block of `extrinsic` samples from the upstream SISO in natural order and replays them as `apriori` for the next SISO. Replay uses the LTE QPP permutation π(i) = (f1·i + f2·i²) mod K (interleave mode) or its inverse (deinterleave mode). The address generator is recursive, so there is no per-K table.

---
 rtl/siso_pkg.sv | 30 +++
 rtl/qpp_addr_gen.sv | 62 ++++++
 rtl/extrinsic_interleaver.sv | 210 +++++++++++++++++++++
 tb/tb_extrinsic_interleaver.sv | 381 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/siso_pkg.sv
// -----------------------------------------------------------------------------
// siso_pkg
// Shared constants and types for the SISO turbo-loop block buffers.
//   KMAX : largest supported block length (RAM depth)
//   DW   : extrinsic / apriori sample width (signed, passed through untouched)
//   AW   : address width, ceil(log2(KMAX))
//   FW   : QPP coefficient width (f1, f2)
//   LW   : block length field width
//   state_e    : buffer FSM states
//   k_is_legal : block length check (40..KMAX, multiple of 8)
// -----------------------------------------------------------------------------
package siso_pkg;

  localparam int KMAX = 6144;
  localparam int DW   = 16;
  localparam int AW   = 13;
  localparam int FW   = 10;
  localparam int LW   = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2
  } state_e;

  function automatic logic k_is_legal(input logic [LW-1:0] k);
    return (k >= LW'(40)) && (k <= LW'(KMAX)) && (k[2:0] == 3'b000);
  endfunction

endpackage

// File: rtl/qpp_addr_gen.sv
// -----------------------------------------------------------------------------
// qpp_addr_gen
// Recursive LTE QPP address generator: pi(i) = (f1*i + f2*i^2) mod K.
// Uses pi(i+1) = pi(i) + g(i), g(i+1) = g(i) + d, with g(0) = f1+f2 and
// d = 2*f2, all mod K. Each update is one AW+1-bit add and one conditional
// subtract, so f1 and f2 must be below K (true for every LTE QPP pair).
// Shared with the parity interleaver.
//   clk, rst : clock, asynchronous active-low reset
//   init     : load pi=0, g=(f1+f2) mod K, d=(2*f2) mod K (wins over step)
//   step     : advance to the next index
//   k        : block length K
//   f1, f2   : QPP coefficients (only sampled on init)
//   pi       : current permuted address
// -----------------------------------------------------------------------------
module qpp_addr_gen
  import siso_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          init,
  input  logic          step,
  input  logic [AW-1:0] k,
  input  logic [FW-1:0] f1,
  input  logic [FW-1:0] f2,
  output logic [AW-1:0] pi
);

  logic [AW-1:0] g_q;
  logic [AW-1:0] d_q;
  logic [AW-1:0] f1_ext;
  logic [AW-1:0] f2_ext;

  assign f1_ext = {{(AW-FW){1'b0}}, f1};
  assign f2_ext = {{(AW-FW){1'b0}}, f2};

  // (a + b) mod m for a, b < m.
  function automatic logic [AW-1:0] add_mod(input logic [AW-1:0] a,
                                            input logic [AW-1:0] b,
                                            input logic [AW-1:0] m);
    logic [AW:0] s;
    s = {1'b0, a} + {1'b0, b};
    return AW'((s >= {1'b0, m}) ? s - {1'b0, m} : s);
  endfunction

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge value of every other register, independent of order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pi  <= '0;
      g_q <= '0;
      d_q <= '0;
    end else if (init) begin
      pi  <= '0;
      g_q <= add_mod(f1_ext, f2_ext, k);
      d_q <= add_mod(f2_ext, f2_ext, k);
    end else if (step) begin
      pi  <= add_mod(pi, g_q, k);
      g_q <= add_mod(g_q, d_q, k);
    end
  end

endmodule

// File: rtl/extrinsic_interleaver.sv
// -----------------------------------------------------------------------------
// extrinsic_interleaver
// Block buffer between two SISO decoders of the turbo loop. Captures one block
// of extrinsic samples and replays them as apriori in QPP-interleaved
// (mode=0: out[i] = in[pi(i)]) or deinterleaved (mode=1: out[pi(j)] = in[j])
// order.
//   clk, rst        : clock, asynchronous active-low reset
//   blklen, f1, f2, mode, valid_blklen : block start, sampled on the strobe
//   extrinsic, valid_extrinsic         : upstream samples, no backpressure
//   ready           : high in IDLE, a new block may be started
//   apriori, valid_apriori, apriori_ready : downstream valid/ready stream
//   block_done      : one-cycle pulse after the last output transfer
//   err             : one-cycle pulse after a rejected (illegal K) start
// -----------------------------------------------------------------------------
module extrinsic_interleaver
  import siso_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic [LW-1:0] blklen,
  input  logic [FW-1:0] f1,
  input  logic [FW-1:0] f2,
  input  logic          mode,
  input  logic          valid_blklen,
  input  logic [DW-1:0] extrinsic,
  input  logic          valid_extrinsic,
  output logic          ready,
  output logic [DW-1:0] apriori,
  output logic          valid_apriori,
  input  logic          apriori_ready,
  output logic          block_done,
  output logic          err
);

  // Block configuration and progress.
  state_e        state_q;
  logic [AW-1:0] k_q;
  logic [AW-1:0] k_last_q;
  logic [FW-1:0] f1_q;
  logic [FW-1:0] f2_q;
  logic          mode_q;
  logic [AW-1:0] idx_q;      // natural-order index i, reused for writes and reads
  logic [AW-1:0] out_cnt_q;  // completed output transfers
  logic          rd_all_q;   // all K reads issued

  // Sample RAM and output path.
  logic [DW-1:0] mem [KMAX];
  logic [DW-1:0] ram_q;
  logic          rd_pend_q;  // ram_q holds a read that still has to enter the FIFO
  logic [DW-1:0] fifo_q [2];
  logic          wr_ptr_q;
  logic          rd_ptr_q;
  logic [1:0]    fifo_cnt_q;

  logic          start_ok;
  logic          wr_en;
  logic          wr_last;
  logic          pop;
  logic          rd_issue;
  logic          rd_last;
  logic          last_xfer;
  logic          gen_init;
  logic          gen_step;
  logic [2:0]    credit_use;
  logic [AW-1:0] pi_addr;
  logic [AW-1:0] cfg_k;
  logic [FW-1:0] cfg_f1;
  logic [FW-1:0] cfg_f2;
  logic [AW-1:0] wr_addr;
  logic [AW-1:0] rd_addr;

  assign valid_apriori = (fifo_cnt_q != 2'd0);
  assign apriori       = fifo_q[rd_ptr_q];
  assign pop           = valid_apriori && apriori_ready;

  assign start_ok  = (state_q == ST_IDLE) && valid_blklen && k_is_legal(blklen);
  assign wr_en     = (state_q == ST_WRITE) && valid_extrinsic;
  assign wr_last   = wr_en && (idx_q == k_last_q);

  // Slots the FIFO will need once the in-flight read lands, counting the
  // entry leaving this cycle as free; this keeps 1/cycle with a 2-deep FIFO.
  assign credit_use = {1'b0, fifo_cnt_q} + {2'b00, rd_pend_q} - {2'b00, pop};
  assign rd_issue   = (state_q == ST_READ) && !rd_all_q && (credit_use < 3'd2);
  assign rd_last    = rd_issue && (idx_q == k_last_q);
  assign last_xfer  = pop && (out_cnt_q == k_last_q);

  // The generator is loaded at block start and again when WRITE hands over
  // to READ; it only walks in the phase that uses the permuted address.
  assign gen_init = start_ok || wr_last;
  assign gen_step = mode_q ? wr_en : rd_issue;

  // NOTE: every signal written here gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    cfg_k  = k_q;
    cfg_f1 = f1_q;
    cfg_f2 = f2_q;
    if (state_q == ST_IDLE) begin
      // At block start the coefficients are not latched yet.
      cfg_k  = blklen[AW-1:0];
      cfg_f1 = f1;
      cfg_f2 = f2;
    end
    wr_addr = mode_q ? pi_addr : idx_q;
    rd_addr = mode_q ? idx_q   : pi_addr;
  end

  qpp_addr_gen u_addr_gen (
    .clk  (clk),
    .rst  (rst),
    .init (gen_init),
    .step (gen_step),
    .k    (cfg_k),
    .f1   (cfg_f1),
    .f2   (cfg_f2),
    .pi   (pi_addr)
  );

  // NOTE: the RAM and its read register have no reset; validity is tracked
  // by rd_pend_q and the FIFO count, which are reset.
  always_ff @(posedge clk) begin
    if (wr_en)    mem[wr_addr] <= extrinsic;
    if (rd_issue) ram_q        <= mem[rd_addr];
  end

  // Output FIFO, two entries; the head is held until it is accepted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fifo_q[0]  <= '0;
      fifo_q[1]  <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      fifo_cnt_q <= 2'd0;
      rd_pend_q  <= 1'b0;
    end else begin
      rd_pend_q <= rd_issue;
      if (rd_pend_q) begin
        fifo_q[wr_ptr_q] <= ram_q;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      fifo_cnt_q <= fifo_cnt_q + {1'b0, rd_pend_q} - {1'b0, pop};
    end
  end

  // Block FSM with registered ready / block_done / err.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      ready      <= 1'b1;
      block_done <= 1'b0;
      err        <= 1'b0;
      k_q        <= '0;
      k_last_q   <= '0;
      f1_q       <= '0;
      f2_q       <= '0;
      mode_q     <= 1'b0;
      idx_q      <= '0;
      out_cnt_q  <= '0;
      rd_all_q   <= 1'b0;
    end else begin
      block_done <= 1'b0;
      err        <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (valid_blklen) begin
            if (start_ok) begin
              k_q      <= blklen[AW-1:0];
              k_last_q <= blklen[AW-1:0] - AW'(1);
              f1_q     <= f1;
              f2_q     <= f2;
              mode_q   <= mode;
              idx_q    <= '0;
              ready    <= 1'b0;
              state_q  <= ST_WRITE;
            end else begin
              err <= 1'b1;
            end
          end
        end
        ST_WRITE: begin
          if (wr_en) begin
            if (wr_last) begin
              idx_q     <= '0;
              out_cnt_q <= '0;
              rd_all_q  <= 1'b0;
              state_q   <= ST_READ;
            end else begin
              idx_q <= idx_q + AW'(1);
            end
          end
        end
        ST_READ: begin
          if (rd_issue) begin
            idx_q <= idx_q + AW'(1);
            if (rd_last) rd_all_q <= 1'b1;
          end
          if (pop) out_cnt_q <= out_cnt_q + AW'(1);
          if (last_xfer) begin
            state_q    <= ST_IDLE;
            block_done <= 1'b1;
            ready      <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_extrinsic_interleaver.sv
// -----------------------------------------------------------------------------
// tb_extrinsic_interleaver
// Self-checking bench for extrinsic_interleaver. Expected outputs come from
// the closed-form QPP formula pi(i) = (f1*i + f2*i^2) mod K applied to the
// data the bench wrote.
// -----------------------------------------------------------------------------
module tb_extrinsic_interleaver;
  import siso_pkg::*;

  logic          clk;
  logic          rst;
  logic [LW-1:0] blklen;
  logic [FW-1:0] f1;
  logic [FW-1:0] f2;
  logic          mode;
  logic          valid_blklen;
  logic [DW-1:0] extrinsic;
  logic          valid_extrinsic;
  logic          ready;
  logic [DW-1:0] apriori;
  logic          valid_apriori;
  logic          apriori_ready;
  logic          block_done;
  logic          err;

  int n_checks;
  int n_fail;

  logic [DW-1:0] din_q[$];
  logic [DW-1:0] got_q[$];
  logic [DW-1:0] exp_q[$];

  int first_valid;
  int last_xfer;
  int done_cyc;
  int done_pulses;
  int stall_bad;
  int ready_bad;
  int err_seen;
  bit timeout;

  extrinsic_interleaver dut (
    .clk             (clk),
    .rst             (rst),
    .blklen          (blklen),
    .f1              (f1),
    .f2              (f2),
    .mode            (mode),
    .valid_blklen    (valid_blklen),
    .extrinsic       (extrinsic),
    .valid_extrinsic (valid_extrinsic),
    .ready           (ready),
    .apriori         (apriori),
    .valid_apriori   (valid_apriori),
    .apriori_ready   (apriori_ready),
    .block_done      (block_done),
    .err             (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------- model
  function automatic int qpp(input int i, input int k, input int f1v, input int f2v);
    longint v;
    v = (longint'(f1v) * i + longint'(f2v) * i * i) % k;
    return int'(v);
  endfunction

  function automatic bit qpp_is_perm(input int k, input int f1v, input int f2v);
    bit seen[];
    seen = new[k];
    for (int i = 0; i < k; i++) begin
      if (seen[qpp(i, k, f1v, f2v)]) return 1'b0;
      seen[qpp(i, k, f1v, f2v)] = 1'b1;
    end
    return 1'b1;
  endfunction

  task automatic build_expect(input int k, input int f1v, input int f2v, input bit md);
    logic [DW-1:0] arr[];
    exp_q.delete();
    if (!md) begin
      for (int i = 0; i < k; i++) exp_q.push_back(din_q[qpp(i, k, f1v, f2v)]);
    end else begin
      arr = new[k];
      for (int j = 0; j < k; j++) arr[qpp(j, k, f1v, f2v)] = din_q[j];
      for (int i = 0; i < k; i++) exp_q.push_back(arr[i]);
    end
  endtask

  function automatic int count_mismatch();
    int n;
    int lim;
    n   = (got_q.size() > exp_q.size()) ? got_q.size() - exp_q.size()
                                         : exp_q.size() - got_q.size();
    lim = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < lim; i++) if (got_q[i] !== exp_q[i]) n++;
    return n;
  endfunction

  // ---------------------------------------------------------------- drivers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_start(input int k, input int f1v, input int f2v, input bit md);
    blklen       = LW'(k);
    f1           = FW'(f1v);
    f2           = FW'(f2v);
    mode         = md;
    valid_blklen = 1'b1;
    tick();
    valid_blklen = 1'b0;
  endtask

  // Writes din_q; optional idle gaps and a stray valid_blklen mid-block.
  task automatic drive_block(input bit gaps, input bit inject);
    int g;
    err_seen = 0;
    foreach (din_q[j]) begin
      g = gaps ? int'($urandom_range(0, 2)) : 0;
      repeat (g) begin
        valid_extrinsic = 1'b0;
        extrinsic       = DW'($urandom);
        tick();
        if (err === 1'b1) err_seen++;
      end
      valid_extrinsic = 1'b1;
      extrinsic       = din_q[j];
      if (inject && j == din_q.size() / 2) begin
        blklen       = LW'(100);
        valid_blklen = 1'b1;
      end
      tick();
      valid_blklen = 1'b0;
      if (err === 1'b1) err_seen++;
    end
    valid_extrinsic = 1'b0;
  endtask

  // Called in the first READ cycle; cycle 0 is that cycle.
  // rdy_mode: 0 always ready, 1 toggling 1,0,1,0, 2 random.
  task automatic collect(input int k, input int rdy_mode, input int max_cycles);
    int cyc;
    bit stalled;
    logic [DW-1:0] held;
    got_q.delete();
    first_valid = -1; last_xfer = -1; done_cyc = -1; done_pulses = 0;
    stall_bad = 0; ready_bad = 0; timeout = 1'b0;
    cyc = 0; stalled = 1'b0; held = '0;
    forever begin
      case (rdy_mode)
        0:       apriori_ready = 1'b1;
        1:       apriori_ready = (cyc % 2 == 0);
        default: apriori_ready = 1'($urandom_range(0, 1));
      endcase
      if (stalled && (valid_apriori !== 1'b1 || apriori !== held)) stall_bad++;
      if (valid_apriori === 1'b1 && first_valid < 0) first_valid = cyc;
      if (valid_apriori === 1'b1 && apriori_ready) begin
        got_q.push_back(apriori);
        last_xfer = cyc;
      end
      stalled = (valid_apriori === 1'b1) && !apriori_ready;
      held    = apriori;
      tick();
      cyc++;
      if (block_done === 1'b1) begin
        done_pulses++;
        if (done_cyc < 0) done_cyc = cyc;
        if (ready !== 1'b1) ready_bad++;
      end else if (got_q.size() < k && ready !== 1'b0) begin
        ready_bad++;
      end
      if (done_cyc >= 0 && cyc > done_cyc) break;
      if (got_q.size() >= k && cyc > last_xfer + 4) break;
      if (cyc > max_cycles) begin
        timeout = 1'b1;
        break;
      end
    end
    apriori_ready = 1'b0;
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    rst = 1'b0;
    blklen = '0; f1 = '0; f2 = '0; mode = 1'b0; valid_blklen = 1'b0;
    extrinsic = '0; valid_extrinsic = 1'b0; apriori_ready = 1'b0;
    repeat (3) tick();
    n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", ready); end
    n_checks++; if (valid_apriori !== 1'b0) begin n_fail++; $display("FAIL reset_valid_apriori: got %b want 0", valid_apriori); end
    n_checks++; if (apriori !== '0) begin n_fail++; $display("FAIL reset_apriori: got %0h want 0", apriori); end
    n_checks++; if (block_done !== 1'b0) begin n_fail++; $display("FAIL reset_block_done: got %b want 0", block_done); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err); end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_interleave_k40();
    logic [DW-1:0] head_exp[4];
    bit seen[40];
    int dup;
    head_exp = '{16'd0, 16'd13, 16'd6, 16'd19};
    din_q.delete();
    for (int i = 0; i < 40; i++) din_q.push_back(DW'(i));
    drive_start(40, 3, 10, 1'b0);
    n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL il40_ready_fall: got %b want 0", ready); end
    drive_block(1'b0, 1'b0);
    collect(40, 0, 200);
    build_expect(40, 3, 10, 1'b0);
    n_checks++; if (timeout) begin n_fail++; $display("FAIL il40_timeout: got %0d outputs want 40", got_q.size()); end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (got_q.size() <= i || got_q[i] !== head_exp[i]) begin
        n_fail++;
        $display("FAIL il40_head[%0d]: got %0d want %0d", i, (got_q.size() > i) ? int'(got_q[i]) : -1, head_exp[i]);
      end
    end
    n_checks++; if (count_mismatch() != 0) begin n_fail++; $display("FAIL il40_sequence: got %0d mismatches want 0", count_mismatch()); end
    dup = 0;
    foreach (got_q[i]) begin
      if (got_q[i] < 40 && !seen[got_q[i]]) seen[got_q[i]] = 1'b1;
      else dup++;
    end
    n_checks++; if (dup != 0 || got_q.size() != 40) begin n_fail++; $display("FAIL il40_permutation: got %0d bad of %0d want 0 of 40", dup, got_q.size()); end
    n_checks++; if (first_valid != 2) begin n_fail++; $display("FAIL il40_first_valid: got cycle %0d want 2", first_valid); end
    n_checks++; if (last_xfer + 1 != 42) begin n_fail++; $display("FAIL il40_read_len: got %0d want 42", last_xfer + 1); end
    n_checks++; if (done_cyc != last_xfer + 1 || done_pulses != 1) begin n_fail++; $display("FAIL il40_block_done: got cycle %0d pulses %0d want cycle %0d pulses 1", done_cyc, done_pulses, last_xfer + 1); end
    n_checks++; if (ready_bad != 0) begin n_fail++; $display("FAIL il40_ready: got %0d bad cycles want 0", ready_bad); end
  endtask

  task automatic test_deinterleave_roundtrip();
    logic [DW-1:0] nat[$];
    for (int i = 0; i < 40; i++) nat.push_back(DW'(i));
    din_q = nat;
    build_expect(40, 3, 10, 1'b0);
    din_q = exp_q;             // interleaved sequence feeds the deinterleaver
    exp_q = nat;
    drive_start(40, 3, 10, 1'b1);
    drive_block(1'b0, 1'b0);
    collect(40, 0, 200);
    n_checks++; if (timeout) begin n_fail++; $display("FAIL rt40_timeout: got %0d outputs want 40", got_q.size()); end
    n_checks++; if (count_mismatch() != 0) begin n_fail++; $display("FAIL rt40_sequence: got %0d mismatches want 0", count_mismatch()); end
    n_checks++; if (done_pulses != 1) begin n_fail++; $display("FAIL rt40_block_done: got %0d pulses want 1", done_pulses); end
  endtask

  task automatic test_k6144();
    din_q.delete();
    for (int i = 0; i < 6144; i++) din_q.push_back(DW'(i));
    drive_start(6144, 263, 480, 1'b0);
    drive_block(1'b0, 1'b0);
    collect(6144, 0, 7000);
    build_expect(6144, 263, 480, 1'b0);
    n_checks++; if (timeout) begin n_fail++; $display("FAIL k6144_timeout: got %0d outputs want 6144", got_q.size()); end
    n_checks++; if (got_q.size() < 2 || got_q[1] !== 16'd743) begin n_fail++; $display("FAIL k6144_out1: got %0d want 743", (got_q.size() > 1) ? int'(got_q[1]) : -1); end
    n_checks++; if (count_mismatch() != 0) begin n_fail++; $display("FAIL k6144_sequence: got %0d mismatches want 0", count_mismatch()); end
    n_checks++; if (last_xfer + 1 != 6146) begin n_fail++; $display("FAIL k6144_read_len: got %0d want 6146", last_xfer + 1); end
    n_checks++; if (first_valid != 2) begin n_fail++; $display("FAIL k6144_first_valid: got %0d want 2", first_valid); end
    n_checks++; if (done_cyc != last_xfer + 1) begin n_fail++; $display("FAIL k6144_block_done: got %0d want %0d", done_cyc, last_xfer + 1); end
  endtask

  task automatic test_backpressure();
    din_q.delete();
    for (int i = 0; i < 40; i++) din_q.push_back(DW'(i));
    drive_start(40, 3, 10, 1'b0);
    drive_block(1'b0, 1'b0);
    collect(40, 1, 300);
    build_expect(40, 3, 10, 1'b0);
    n_checks++; if (timeout) begin n_fail++; $display("FAIL bp_timeout: got %0d outputs want 40", got_q.size()); end
    n_checks++; if (stall_bad != 0) begin n_fail++; $display("FAIL bp_stable: got %0d unstable stalls want 0", stall_bad); end
    n_checks++; if (got_q.size() != 40) begin n_fail++; $display("FAIL bp_count: got %0d transfers want 40", got_q.size()); end
    n_checks++; if (count_mismatch() != 0) begin n_fail++; $display("FAIL bp_sequence: got %0d mismatches want 0", count_mismatch()); end
    n_checks++; if (done_cyc != last_xfer + 1 || done_pulses != 1) begin n_fail++; $display("FAIL bp_block_done: got cycle %0d pulses %0d want cycle %0d pulses 1", done_cyc, done_pulses, last_xfer + 1); end
  endtask

  task automatic test_illegal();
    int bad_k[2];
    int outs;
    bad_k = '{100, 32};
    foreach (bad_k[n]) begin
      drive_start(bad_k[n], 3, 10, 1'b0);
      n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL illegal_err_k%0d: got %b want 1", bad_k[n], err); end
      n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL illegal_ready_k%0d: got %b want 1", bad_k[n], ready); end
      tick();
      n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL illegal_err_pulse_k%0d: got %b want 0", bad_k[n], err); end
    end
    outs = 0;
    apriori_ready = 1'b1;
    for (int i = 0; i < 15; i++) begin
      valid_extrinsic = (i < 5);
      extrinsic       = DW'($urandom);
      tick();
      if (valid_apriori === 1'b1 || ready !== 1'b1) outs++;
    end
    valid_extrinsic = 1'b0;
    apriori_ready   = 1'b0;
    n_checks++; if (outs != 0) begin n_fail++; $display("FAIL illegal_no_output: got %0d bad cycles want 0", outs); end
  endtask

  task automatic test_reset_mid_read();
    int n;
    int cyc;
    din_q.delete();
    for (int i = 0; i < 40; i++) din_q.push_back(DW'($urandom));
    drive_start(40, 3, 10, 1'b0);
    drive_block(1'b0, 1'b0);
    n = 0; cyc = 0;
    apriori_ready = 1'b1;
    while (n < 10 && cyc < 100) begin
      if (valid_apriori === 1'b1) n++;
      tick();
      cyc++;
    end
    n_checks++; if (n != 10) begin n_fail++; $display("FAIL rstmid_outputs: got %0d want 10", n); end
    #2 rst = 1'b0;
    #1;
    n_checks++; if (valid_apriori !== 1'b0 || apriori !== '0) begin n_fail++; $display("FAIL rstmid_out: got valid %b data %0h want 0 0", valid_apriori, apriori); end
    n_checks++; if (ready !== 1'b1 || block_done !== 1'b0 || err !== 1'b0) begin n_fail++; $display("FAIL rstmid_flags: got ready %b done %b err %b want 1 0 0", ready, block_done, err); end
    apriori_ready = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    din_q.delete();
    for (int i = 0; i < 40; i++) din_q.push_back(DW'($urandom));
    drive_start(40, 3, 10, 1'b0);
    drive_block(1'b0, 1'b0);
    collect(40, 0, 200);
    build_expect(40, 3, 10, 1'b0);
    n_checks++; if (timeout || count_mismatch() != 0) begin n_fail++; $display("FAIL rstmid_fresh_block: got %0d mismatches timeout %0d want 0 0", count_mismatch(), timeout); end
  endtask

  task automatic test_random_blocks();
    int kt[12];
    int f1t[12];
    int f2t[12];
    int sel;
    bit md;
    kt  = '{40, 48, 56, 64, 72, 80, 88, 96, 104, 112, 120, 128};
    f1t = '{3, 7, 19, 7, 7, 11, 5, 11, 7, 41, 103, 15};
    f2t = '{10, 12, 42, 16, 18, 20, 22, 24, 26, 84, 90, 32};
    for (int b = 0; b < 5; b++) begin
      sel = int'($urandom_range(0, 11));
      md  = 1'($urandom_range(0, 1));
      // Deinterleave only with a true permutation, else RAM holes are undefined.
      if (!qpp_is_perm(kt[sel], f1t[sel], f2t[sel])) md = 1'b0;
      din_q.delete();
      for (int i = 0; i < kt[sel]; i++) din_q.push_back(DW'($urandom));
      drive_start(kt[sel], f1t[sel], f2t[sel], md);
      drive_block(1'b1, 1'b1);
      collect(kt[sel], 2, kt[sel] * 6 + 50);
      build_expect(kt[sel], f1t[sel], f2t[sel], md);
      n_checks++; if (err_seen != 0) begin n_fail++; $display("FAIL rand%0d_stray_start_err: got %0d err pulses want 0", b, err_seen); end
      n_checks++; if (timeout || count_mismatch() != 0) begin n_fail++; $display("FAIL rand%0d_sequence K=%0d mode=%0d: got %0d mismatches timeout %0d want 0 0", b, kt[sel], md, count_mismatch(), timeout); end
      n_checks++; if (stall_bad != 0 || done_pulses != 1 || done_cyc != last_xfer + 1) begin n_fail++; $display("FAIL rand%0d_handshake: got stalls %0d pulses %0d done %0d want 0 1 %0d", b, stall_bad, done_pulses, done_cyc, last_xfer + 1); end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_interleave_k40();
    test_deinterleave_roundtrip();
    test_k6144();
    test_backpressure();
    test_illegal();
    test_reset_mid_read();
    test_random_blocks();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
